block_mem_model: RTL and testbench

BLOCK_MEM_MODEL -- requirements
Module: block_mem_model

---
 rtl/mem_model_pkg.sv | 25 ++
 rtl/block_mem_array.sv | 30 +++
 rtl/block_mem_model.sv | 161 ++++++++++++++++
 tb/tb_block_mem_model.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Purpose : shared types and default parameters for the block memory model.
// Contents: FSM state enum, access-kind enum, default parameter constants.
// Latency/backpressure: n/a (types only).
package mem_model_pkg;

   localparam int DEF_ADDR_W          = 32;
   localparam int DEF_WORD_W          = 32;
   localparam int DEF_WORDS_PER_BLOCK = 16;
   localparam int DEF_DEPTH_WORDS     = 4096;
   localparam int DEF_LATENCY         = 4;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      WAIT,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      READ,
      WRITE_WORD,
      WRITE_BLOCK
   } kind_e;

endpackage

// File: rtl/block_mem_array.sv
// Purpose : block-wide storage, one row per cache block, per-byte write enables.
// Ports   : clk_i; we_i/waddr_i/wdata_i sync write; raddr_i -> rdata_o async read.
// Latency/backpressure: write commits at the clock edge, read is combinational; no backpressure.
module block_mem_array #(
   parameter int ROWS   = 256,
   parameter int ROW_W  = 512,
   parameter int ROW_AW = 8
) (
   input  logic                 clk_i,
   input  logic [ROW_W/8-1:0]   we_i,
   input  logic [ROW_AW-1:0]    waddr_i,
   input  logic [ROW_W-1:0]     wdata_i,
   input  logic [ROW_AW-1:0]    raddr_i,
   output logic [ROW_W-1:0]     rdata_o
);

   // No reset term: contents are only ever restored by the owner's init sweep.
   logic [ROW_W-1:0] mem_q [ROWS];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < ROW_W/8; b++) begin
         if (we_i[b]) begin
            mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/block_mem_model.sv
// Purpose : behavioural main-memory model serving block reads, word writes and block writes.
// Ports   : clk/rst; main_mem_* request/data; main_mem_ready completion pulse; busy when not IDLE.
// Latency/backpressure: ready pulses LATENCY+1 edges after acceptance; requests outside IDLE are ignored.
module block_mem_model
   import mem_model_pkg::*;
#(
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int WORD_W          = DEF_WORD_W,
   parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
   parameter int DEPTH_WORDS     = DEF_DEPTH_WORDS,
   parameter int LATENCY         = DEF_LATENCY
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [ADDR_W-1:0]                   main_mem_addr,
   input  logic                                main_mem_read_req,
   input  logic                                main_mem_write_req,
   input  logic                                main_mem_block_write_req,
   input  logic [WORD_W-1:0]                   main_mem_data_out,
   input  logic [WORD_W/8-1:0]                 main_mem_byte_en,
   input  logic [WORD_W*WORDS_PER_BLOCK-1:0]   main_mem_block_out,
   output logic [WORD_W*WORDS_PER_BLOCK-1:0]   main_mem_data_in,
   output logic                                main_mem_ready,
   output logic                                busy
);

   localparam int BPW    = WORD_W/8;
   localparam int BLK_W  = WORD_W*WORDS_PER_BLOCK;
   localparam int NB     = BLK_W/8;
   localparam int ROWS   = DEPTH_WORDS/WORDS_PER_BLOCK;
   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
   localparam int ROW_AW = IDX_W - OFF_W;
   localparam int CNT_W  = $clog2(LATENCY+1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   kind_e              kind_q,  kind_d;
   logic [IDX_W-1:0]   widx_q,  widx_d;
   logic [WORD_W-1:0]  wdat_q,  wdat_d;
   logic [BPW-1:0]     be_q,    be_d;
   logic [BLK_W-1:0]   blk_q,   blk_d;
   logic [BLK_W-1:0]   rdat_q,  rdat_d;

   logic [NB-1:0]      arr_we;
   logic [ROW_AW-1:0]  arr_waddr;
   logic [BLK_W-1:0]   arr_wdata;
   logic [BLK_W-1:0]   arr_rdata;

   // Only the word-index bits select storage; byte offset and upper bits alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{main_mem_addr[1:0], main_mem_addr[ADDR_W-1:IDX_W+2]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      kind_d    = kind_q;
      widx_d    = widx_q;
      wdat_d    = wdat_q;
      be_d      = be_q;
      blk_d     = blk_q;
      rdat_d    = rdat_q;
      arr_we    = '0;
      arr_waddr = widx_q[IDX_W-1:OFF_W];
      arr_wdata = {WORDS_PER_BLOCK{wdat_q}};

      case (state_q)
         INIT: begin
            // Sweep one word per cycle so word k holds the value k.
            arr_we    = NB'({BPW{1'b1}}) << (int'(idx_q[OFF_W-1:0]) * BPW);
            arr_waddr = idx_q[IDX_W-1:OFF_W];
            arr_wdata = {WORDS_PER_BLOCK{WORD_W'(idx_q)}};
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(DEPTH_WORDS-1)) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (main_mem_read_req || main_mem_block_write_req || main_mem_write_req) begin
               widx_d  = main_mem_addr[IDX_W+1:2];
               wdat_d  = main_mem_data_out;
               be_d    = main_mem_byte_en;
               blk_d   = main_mem_block_out;
               cnt_d   = '0;
               state_d = WAIT;
               // Fixed priority; the losers are simply dropped.
               if (main_mem_read_req)             kind_d = READ;
               else if (main_mem_block_write_req) kind_d = WRITE_BLOCK;
               else                               kind_d = WRITE_WORD;
            end
         end
         WAIT: begin
            // The access takes effect on the edge that enters RESP.
            if (cnt_q == CNT_W'(LATENCY)) begin
               state_d = RESP;
               case (kind_q)
                  READ:        rdat_d = arr_rdata;
                  WRITE_WORD:  arr_we = NB'(be_q) << (int'(widx_q[OFF_W-1:0]) * BPW);
                  WRITE_BLOCK: begin
                     arr_we    = '1;
                     arr_wdata = blk_q;
                  end
                  default:     arr_we = '0;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = INIT;
      endcase

      // Reset aborts any in-flight commit, including the init sweep.
      if (rst) begin
         arr_we = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rdat_q  <= rdat_d;
      end
   end

   // Request capture registers need no reset; they are loaded before use.
   always_ff @(posedge clk) begin
      kind_q <= kind_d;
      widx_q <= widx_d;
      wdat_q <= wdat_d;
      be_q   <= be_d;
      blk_q  <= blk_d;
   end

   block_mem_array #(
      .ROWS   (ROWS),
      .ROW_W  (BLK_W),
      .ROW_AW (ROW_AW)
   ) u_array (
      .clk_i   (clk),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .raddr_i (widx_q[IDX_W-1:OFF_W]),
      .rdata_o (arr_rdata)
   );

   assign main_mem_data_in = rdat_q;
   assign main_mem_ready   = (state_q == RESP);
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_block_mem_model.sv
// Purpose : directed self-checking bench for block_mem_model at default parameters.
// Ports   : none; drives the DUT from initial-block tasks, samples 1 time unit after posedge.
// Latency/backpressure: expects ready LATENCY+1 edges after acceptance.
module tb_block_mem_model;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  main_mem_addr;
   logic         main_mem_read_req;
   logic         main_mem_write_req;
   logic         main_mem_block_write_req;
   logic [31:0]  main_mem_data_out;
   logic [3:0]   main_mem_byte_en;
   logic [511:0] main_mem_block_out;
   logic [511:0] main_mem_data_in;
   logic         main_mem_ready;
   logic         busy;

   int n_checks  = 0;
   int n_fail    = 0;
   int ready_cnt = 0;

   always #5 clk = ~clk;

   block_mem_model dut (
      .clk                      (clk),
      .rst                      (rst),
      .main_mem_addr            (main_mem_addr),
      .main_mem_read_req        (main_mem_read_req),
      .main_mem_write_req       (main_mem_write_req),
      .main_mem_block_write_req (main_mem_block_write_req),
      .main_mem_data_out        (main_mem_data_out),
      .main_mem_byte_en         (main_mem_byte_en),
      .main_mem_block_out       (main_mem_block_out),
      .main_mem_data_in         (main_mem_data_in),
      .main_mem_ready           (main_mem_ready),
      .busy                     (busy)
   );

   // Count every cycle in which ready is high, sampled mid-cycle.
   always @(negedge clk) begin
      if (main_mem_ready) ready_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word(input int i);
      return main_mem_data_in[i*32 +: 32];
   endfunction

   // Holds the request until ready, returns edges from acceptance to ready
   // (99 if it never came), then steps back into IDLE.
   task automatic req(input logic rd, input logic wr, input logic bw,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [511:0] blk,
                      output int lat);
      main_mem_addr            = addr;
      main_mem_data_out        = data;
      main_mem_byte_en         = be;
      main_mem_block_out       = blk;
      main_mem_read_req        = rd;
      main_mem_write_req       = wr;
      main_mem_block_write_req = bw;
      tick();
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (main_mem_ready) begin
            lat = n;
            break;
         end
      end
      main_mem_read_req        = 1'b0;
      main_mem_write_req       = 1'b0;
      main_mem_block_write_req = 1'b0;
      tick();
   endtask

   task automatic wait_init(output int n);
      n = 99999;
      for (int k = 1; k <= 5000; k++) begin
         tick();
         if (!busy) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic chk_block(input string tag, input logic [31:0] base);
      for (int i = 0; i < 16; i++) begin
         check(tag, word(i), base + 32'(i));
      end
   endtask

   initial begin
      int lat;
      int n;
      int c0;
      logic [511:0] blk;

      rst                      = 1'b1;
      main_mem_addr            = '0;
      main_mem_read_req        = 1'b0;
      main_mem_write_req       = 1'b0;
      main_mem_block_write_req = 1'b0;
      main_mem_data_out        = '0;
      main_mem_byte_en         = '0;
      main_mem_block_out       = '0;

      tick();
      tick();
      check("rst_ready", {31'b0, main_mem_ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd1);
      check("rst_data_zero", {31'b0, |main_mem_data_in}, 32'd0);
      rst = 1'b0;
      wait_init(n);
      check("init_cycles", n, 32'd4096);

      // Plain block read after init.
      req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, '0, lat);
      check("rd40_lat", lat, 32'd5);
      chk_block("rd40_data", 32'h10);
      check("rd40_pulses", ready_cnt, 32'd1);
      check("rd40_ready_drop", {31'b0, main_mem_ready}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);

      // Full word write, then read it back; read data holds across the write.
      req(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, '0, lat);
      check("ww100_lat", lat, 32'd5);
      check("hold_after_write", word(0), 32'h10);
      req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, '0, lat);
      check("rd100_w0", word(0), 32'hDEADBEEF);
      check("rd100_w1", word(1), 32'h41);
      check("rd100_w2", word(2), 32'h42);

      // Byte-masked write touches only byte 0 of word 1.
      req(1'b0, 1'b1, 1'b0, 32'h104, 32'h112233CC, 4'h1, '0, lat);
      req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, '0, lat);
      check("be_w1", word(1), 32'h000000CC);
      check("be_w0", word(0), 32'hDEADBEEF);
      check("be_w2", word(2), 32'h42);

      // Upper address bits alias.
      req(1'b1, 1'b0, 1'b0, 32'h00004040, 32'h0, 4'h0, '0, lat);
      check("alias_lat", lat, 32'd5);
      chk_block("alias_data", 32'h10);

      // Read and word write together: read wins, write dropped.
      c0 = ready_cnt;
      req(1'b1, 1'b1, 1'b0, 32'h180, 32'hAAAAAAAA, 4'hF, '0, lat);
      check("simul_lat", lat, 32'd5);
      check("simul_w0", word(0), 32'h60);
      check("simul_w15", word(15), 32'h6F);
      tick();
      tick();
      tick();
      check("simul_pulses", ready_cnt - c0, 32'd1);
      req(1'b1, 1'b0, 1'b0, 32'h180, 32'h0, 4'h0, '0, lat);
      check("simul_unchanged", word(0), 32'h60);

      // Block write, read back.
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'hB0000000 + 32'(i);
      req(1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 4'h0, blk, lat);
      check("bw300_lat", lat, 32'd5);
      req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0, '0, lat);
      chk_block("bw300_data", 32'hB0000000);

      // Reset in the middle of a block write's WAIT.
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'h5A5A5A5A;
      main_mem_addr            = 32'h200;
      main_mem_block_out       = blk;
      main_mem_block_write_req = 1'b1;
      tick();
      tick();
      tick();
      check("abort_in_wait_busy", {31'b0, busy}, 32'd1);
      main_mem_block_write_req = 1'b0;
      rst = 1'b1;
      c0 = ready_cnt;
      tick();
      check("abort_rst_busy", {31'b0, busy}, 32'd1);
      check("abort_rst_data_zero", {31'b0, |main_mem_data_in}, 32'd0);
      rst = 1'b0;
      wait_init(n);
      check("abort_init_cycles", n, 32'd4096);
      check("abort_pulses", ready_cnt - c0, 32'd0);
      req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 4'h0, '0, lat);
      chk_block("abort_rd200", 32'h80);
      req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0, '0, lat);
      check("reinit_rd300", word(0), 32'hC0);
      req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, '0, lat);
      check("reinit_rd100", word(0), 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
